regbank_read_port: RTL and testbench

REGBANK_READ_PORT -- requirements
Module: regbank_read_port

---
 rtl/regbank_pkg.sv | 14 +
 rtl/regbank_read_mux.sv | 32 +++
 rtl/regbank_read_port.sv | 137 +++++++++++++
 tb/tb_regbank_read_port.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared sizing and output-stage state encoding for the register-bank read port.
package regbank_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/regbank_read_mux.sv
// One-operand NUM_REGS:1 word select; with REGREAD_BYPASS_EN defined, a same-cycle
// bank write to the selected register is forwarded from wr_bus.
module regbank_read_mux #(
  parameter int DATA_W   = regbank_pkg::DATA_W,
  parameter int NUM_REGS = regbank_pkg::NUM_REGS
) (
  input  logic [NUM_REGS*DATA_W-1:0]    reg_data,
`ifdef REGREAD_BYPASS_EN
  input  logic [DATA_W-1:0]             wr_bus,
  input  logic [NUM_REGS-1:0]           wr_enable,
`endif
  input  logic [regbank_pkg::ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0]             rdata
);

  localparam int AW = regbank_pkg::ADDR_W;

  always_comb begin
    // NOTE: default every comb output before the loop so no path leaves it unassigned (no latch).
    rdata = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr == AW'(i)) begin
`ifdef REGREAD_BYPASS_EN
        rdata = wr_enable[i] ? wr_bus : reg_data[i*DATA_W +: DATA_W];
`else
        rdata = reg_data[i*DATA_W +: DATA_W];
`endif
      end
    end
  end

endmodule

// File: rtl/regbank_read_port.sv
// Two-operand register-bank read port with a 2-deep (output + skid) response stage.
// Optional REGREAD_BYPASS_EN forwards same-cycle bank writes into the captured data.
module regbank_read_port #(
  parameter int DATA_W   = regbank_pkg::DATA_W,
  parameter int NUM_REGS = regbank_pkg::NUM_REGS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REGS*DATA_W-1:0]     reg_data,
  input  logic [DATA_W-1:0]              wr_bus,
  input  logic [NUM_REGS-1:0]            wr_enable,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [regbank_pkg::ADDR_W-1:0] raddr_a,
  input  logic [regbank_pkg::ADDR_W-1:0] raddr_b,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_W-1:0]              rdata_a,
  output logic [DATA_W-1:0]              rdata_b,
  output logic                           wr_conflict
);

  import regbank_pkg::*;

  state_t            state_q, state_d;
  logic              accept;
  logic              load_out, load_skid, skid_to_out;
  logic              multi_hot;
  logic [DATA_W-1:0] cap_a, cap_b;
  logic [DATA_W-1:0] out_a_q, out_b_q, skid_a_q, skid_b_q;

  assign accept    = req_valid & req_ready;
  assign multi_hot = |(wr_enable & (wr_enable - NUM_REGS'(1)));

`ifdef REGREAD_BYPASS_EN
  regbank_read_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mux_a (
    .reg_data (reg_data),
    .wr_bus   (wr_bus),
    .wr_enable(wr_enable),
    .raddr    (raddr_a),
    .rdata    (cap_a)
  );
  regbank_read_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mux_b (
    .reg_data (reg_data),
    .wr_bus   (wr_bus),
    .wr_enable(wr_enable),
    .raddr    (raddr_b),
    .rdata    (cap_b)
  );
`else
  logic unused_wr_bus;
  assign unused_wr_bus = ^wr_bus;

  regbank_read_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mux_a (
    .reg_data(reg_data),
    .raddr   (raddr_a),
    .rdata   (cap_a)
  );
  regbank_read_mux #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mux_b (
    .reg_data(reg_data),
    .raddr   (raddr_b),
    .rdata   (cap_b)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = HOLD;
      HOLD: begin
        if (accept && !resp_ready)      state_d = SKID;
        else if (!accept && resp_ready) state_d = EMPTY;
      end
      SKID:    if (resp_ready) state_d = HOLD;
      default: state_d = EMPTY;
    endcase
  end

  // Skid only fills while the output register is held, so accept never coincides with SKID.
  always_comb begin
    resp_valid  = (state_q != EMPTY);
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state_q)
      EMPTY: load_out = accept;
      HOLD: begin
        load_out  = accept & resp_ready;
        load_skid = accept & ~resp_ready;
      end
      SKID:    skid_to_out = resp_ready;
      default: ;
    endcase
  end

  // NOTE: the data registers are reset on purpose: rdata must read zero during reset and stale data must never resurface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_a_q  <= '0;
      out_b_q  <= '0;
      skid_a_q <= '0;
      skid_b_q <= '0;
    end else begin
      if (skid_to_out) begin
        out_a_q <= skid_a_q;
        out_b_q <= skid_b_q;
      end else if (load_out) begin
        out_a_q <= cap_a;
        out_b_q <= cap_b;
      end
      if (load_skid) begin
        skid_a_q <= cap_a;
        skid_b_q <= cap_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready   <= 1'b1;
      wr_conflict <= 1'b0;
    end else begin
      req_ready <= (state_d != SKID);
      if (multi_hot) wr_conflict <= 1'b1;
    end
  end

  assign rdata_a = out_a_q;
  assign rdata_b = out_b_q;

endmodule

// File: tb/tb_regbank_read_port.sv
// Self-checking bench for regbank_read_port: fixed vector table, corner-case sequences,
// and randomized traffic checked against a two-entry response queue model.
module tb_regbank_read_port;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] reg_data;
  logic [15:0]  wr_bus;
  logic [15:0]  wr_enable;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   raddr_a, raddr_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [15:0]  rdata_a, rdata_b;
  logic         wr_conflict;

  logic [15:0]  regs [16];
  logic [15:0]  mq_a [$];
  logic [15:0]  mq_b [$];
  bit           m_conf;
  int           n_vec = 0;
  int           n_err = 0;

  typedef struct {
    bit          rv;
    bit          rr;
    logic [3:0]  a;
    logic [3:0]  b;
    bit          exp_valid;
    bit          exp_ready;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  always_comb begin
    reg_data = '0;
    for (int i = 0; i < 16; i++) reg_data[i*16 +: 16] = regs[i];
  end

  regbank_read_port dut (
    .clk        (clk),
    .reset      (reset),
    .reg_data   (reg_data),
    .wr_bus     (wr_bus),
    .wr_enable  (wr_enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .raddr_a    (raddr_a),
    .raddr_b    (raddr_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .wr_conflict(wr_conflict)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [3:0] addr, input logic [15:0] we,
                                             input logic [15:0] wb);
`ifdef REGREAD_BYPASS_EN
    if (we[addr]) return wb;
`endif
    return regs[addr];
  endfunction

  // One clock: drive inputs, advance the queue model, clock, then apply the bank write.
  task automatic drive_cycle(input bit rv, input bit rr, input logic [3:0] a, input logic [3:0] b,
                             input logic [15:0] we, input logic [15:0] wb);
    logic [15:0] va, vb;
    bit          acc;
    req_valid  = rv;
    resp_ready = rr;
    raddr_a    = a;
    raddr_b    = b;
    wr_enable  = we;
    wr_bus     = wb;
    acc = rv && (mq_a.size() < 2);
    va  = model_read(a, we, wb);
    vb  = model_read(b, we, wb);
    if (rr && mq_a.size() > 0) begin
      void'(mq_a.pop_front());
      void'(mq_b.pop_front());
    end
    if (acc) begin
      mq_a.push_back(va);
      mq_b.push_back(vb);
    end
    if ($countones(we) > 1) m_conf = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) if (we[i]) regs[i] = wb;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'(mq_a.size() > 0));
    check({tag, ".req_ready"}, 32'(req_ready), 32'(mq_a.size() < 2));
    check({tag, ".wr_conflict"}, 32'(wr_conflict), 32'(m_conf));
    if (mq_a.size() > 0) begin
      check({tag, ".rdata_a"}, 32'(rdata_a), 32'(mq_a[0]));
      check({tag, ".rdata_b"}, 32'(rdata_b), 32'(mq_b[0]));
    end
  endtask

  task automatic model_clear();
    mq_a.delete();
    mq_b.delete();
    m_conf = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_byp;
    reset      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    raddr_a    = '0;
    raddr_b    = '0;
    wr_enable  = '0;
    wr_bus     = '0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0A00 + 16'(i);
    regs[1] = 16'h1111;
    regs[2] = 16'h2222;
    regs[3] = 16'h1234;
    regs[5] = 16'h0055;
    regs[9] = 16'hBEEF;
    model_clear();

    tbl[0] = '{1'b1, 1'b1, 4'd3, 4'd9, 1'b1, 1'b1, 16'h1234, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1, 16'h1111, 16'h1111};
    tbl[3] = '{1'b1, 1'b0, 4'd2, 4'd2, 1'b1, 1'b0, 16'h1111, 16'h1111};
    tbl[4] = '{1'b1, 1'b0, 4'd3, 4'd3, 1'b1, 1'b0, 16'h1111, 16'h1111};
    tbl[5] = '{1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 16'h2222, 16'h2222};
    tbl[6] = '{1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 16'h1234, 16'h1234};
    tbl[7] = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 16'h0000, 16'h0000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rdata_a", 32'(rdata_a), 32'd0);
    check("rst.rdata_b", 32'(rdata_b), 32'd0);
    check("rst.wr_conflict", 32'(wr_conflict), 32'd0);
    reset = 1'b1;

    // Basic read, same-address read, skid fill/drain ordering
    for (int i = 0; i < 8; i++) begin
      drive_cycle(tbl[i].rv, tbl[i].rr, tbl[i].a, tbl[i].b, 16'h0000, 16'h0000);
      check($sformatf("tbl%0d.resp_valid", i), 32'(resp_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d.req_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d.rdata_a", i), 32'(rdata_a), 32'(tbl[i].exp_a));
        check($sformatf("tbl%0d.rdata_b", i), 32'(rdata_b), 32'(tbl[i].exp_b));
      end
    end

    // Same-cycle write to the register being read
`ifdef REGREAD_BYPASS_EN
    exp_byp = 16'hAAAA;
`else
    exp_byp = 16'h1234;
`endif
    drive_cycle(1'b1, 1'b1, 4'd3, 4'd9, 16'h0008, 16'hAAAA);
    check("byp.resp_valid", 32'(resp_valid), 32'd1);
    check("byp.rdata_a", 32'(rdata_a), 32'(exp_byp));
    check("byp.rdata_b", 32'(rdata_b), 32'hBEEF);
    drive_cycle(1'b0, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000);
    check("byp.drain", 32'(resp_valid), 32'd0);

    // Held response is a snapshot
    drive_cycle(1'b1, 1'b0, 4'd5, 4'd5, 16'h0000, 16'h0000);
    check("snap.hold_a", 32'(rdata_a), 32'h0055);
    drive_cycle(1'b0, 1'b0, 4'd0, 4'd0, 16'h0020, 16'hFFFF);
    check("snap.after_wr_valid", 32'(resp_valid), 32'd1);
    check("snap.after_wr_a", 32'(rdata_a), 32'h0055);
    drive_cycle(1'b0, 1'b0, 4'd5, 4'd5, 16'h0000, 16'h0000);
    check("snap.still_a", 32'(rdata_a), 32'h0055);
    check("snap.still_b", 32'(rdata_b), 32'h0055);
    drive_cycle(1'b0, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000);
    check("snap.drain", 32'(resp_valid), 32'd0);

    // Sticky write-conflict flag
    check("conf.before", 32'(wr_conflict), 32'd0);
    drive_cycle(1'b0, 1'b1, 4'd0, 4'd0, 16'h0011, 16'h5A5A);
    check("conf.set", 32'(wr_conflict), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000);
      check($sformatf("conf.sticky%0d", i), 32'(wr_conflict), 32'd1);
    end

    // Asynchronous reset while in SKID
    drive_cycle(1'b1, 1'b0, 4'd1, 4'd2, 16'h0000, 16'h0000);
    drive_cycle(1'b1, 1'b0, 4'd2, 4'd1, 16'h0000, 16'h0000);
    check("skid.req_ready", 32'(req_ready), 32'd0);
    check("skid.resp_valid", 32'(resp_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst.resp_valid", 32'(resp_valid), 32'd0);
    check("arst.req_ready", 32'(req_ready), 32'd1);
    check("arst.rdata_a", 32'(rdata_a), 32'd0);
    check("arst.rdata_b", 32'(rdata_b), 32'd0);
    check("arst.wr_conflict", 32'(wr_conflict), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000);
      check($sformatf("arst.no_stale%0d", i), 32'(resp_valid), 32'd0);
      check($sformatf("arst.ready%0d", i), 32'(req_ready), 32'd1);
    end

    // Randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      bit          rv, rr;
      logic [3:0]  a, b;
      logic [15:0] we, wb;
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      a  = 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
      we = '0;
      case ($urandom_range(0, 3))
        0:       we = '0;
        default: we[$urandom_range(0, 15)] = 1'b1;
      endcase
      if ($urandom_range(0, 99) == 0) we[$urandom_range(0, 15)] = 1'b1;
      wb = 16'($urandom);
      drive_cycle(rv, rr, a, b, we, wb);
      check_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
